rsa_exp_sequencer: RTL

- Square-and-multiply controller for modular exponentiation in the RSA datapath.
- Scans the exponent MSB-first and drives the 2-bit select codes of the two operand muxes: 00 = constant one, 01 = operand A (result register), 10 = operand B (base), 11 = zero.
- Handshakes with the modular multiplier (mul_start/mul_done) and pulses the result-register load.
- Sits between the top-level command interface and the operand-mux/multiplier datapath.

---
 rtl/rsa_exp_sequencer_pkg.sv | 23 ++
 rtl/rsa_exp_sequencer_if.sv | 25 ++
 rtl/rsa_exp_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rsa_exp_sequencer_pkg.sv
// Shared definitions for the RSA exponentiation sequencer and its operand muxes.
// The mux select codes live here so the sequencer and the datapath decode them identically.
package rsa_pkg;

    localparam logic [1:0] SEL_ONE  = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam int DEFAULT_EXP_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SQ_GO   = 3'd2,
        ST_SQ_WAIT = 3'd3,
        ST_MU_GO   = 3'd4,
        ST_MU_WAIT = 3'd5,
        ST_NEXT    = 3'd6,
        ST_DONE    = 3'd7
    } seq_state_e;

endpackage

// File: rtl/rsa_exp_sequencer_if.sv
// Command and datapath-control signals of the exponentiation sequencer.
// master = sequencer side, slave = command source plus mux/multiplier datapath.
interface rsa_exp_sequencer_if #(
    parameter int EXP_WIDTH = rsa_pkg::DEFAULT_EXP_WIDTH
);
    logic                 start;
    logic [EXP_WIDTH-1:0] exponent;
    logic                 mul_done;
    logic [1:0]           sel_x;
    logic [1:0]           sel_y;
    logic                 mul_start;
    logic                 load_result;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, exponent, mul_done,
        output sel_x, sel_y, mul_start, load_result, busy, done
    );

    modport slave (
        output start, exponent, mul_done,
        input  sel_x, sel_y, mul_start, load_result, busy, done
    );
endinterface

// File: rtl/rsa_exp_sequencer.sv
// Square-and-multiply controller: scans the exponent MSB-first, steers the operand muxes
// and handshakes with the modular multiplier. Optional macro: RSA_SKIP_LEADING_ZEROS_EN.
module rsa_exp_sequencer
    import rsa_pkg::*;
#(
    parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH,
    parameter int CNT_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rsa_exp_sequencer_if.master bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_TOP = CNT_WIDTH'(EXP_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    seq_state_e           state_reg, state_next;
    logic [EXP_WIDTH-1:0] exp_reg, exp_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0] cnt_dec;
    logic                 cur_bit;

    logic [1:0] sel_x_c, sel_y_c;
    logic       mul_start_c, load_result_c, done_c;

`ifdef RSA_SKIP_LEADING_ZEROS_EN
    // Set once the first 1 bit has been multiplied in; before that, result is still 1.
    logic seen_one_reg, seen_one_next;
`endif

    assign cnt_dec = cnt_reg - CNT_ONE;
    assign cur_bit = exp_reg[cnt_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            exp_reg      <= '0;
            cnt_reg      <= '0;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
            seen_one_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            exp_reg      <= exp_next;
            cnt_reg      <= cnt_next;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
            seen_one_reg <= seen_one_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        exp_next      = exp_reg;
        cnt_next      = cnt_reg;
        sel_x_c       = SEL_ZERO;
        sel_y_c       = SEL_ZERO;
        mul_start_c   = 1'b0;
        load_result_c = 1'b0;
        done_c        = 1'b0;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
        seen_one_next = seen_one_reg;
`endif

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    exp_next   = bus.exponent;
                    cnt_next   = CNT_TOP;
                    state_next = ST_INIT;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
                    seen_one_next = 1'b0;
`endif
                end
            end

            ST_INIT: begin
                sel_x_c       = SEL_ONE;
                load_result_c = 1'b1;
                if (exp_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
`ifdef RSA_SKIP_LEADING_ZEROS_EN
                    state_next = cur_bit ? ST_MU_GO : ST_NEXT;
`else
                    state_next = ST_SQ_GO;
`endif
                end
            end

            ST_SQ_GO: begin
                sel_x_c     = SEL_A;
                sel_y_c     = SEL_A;
                mul_start_c = 1'b1;
                state_next  = ST_SQ_WAIT;
            end

            ST_SQ_WAIT: begin
                sel_x_c = SEL_A;
                sel_y_c = SEL_A;
                if (bus.mul_done) begin
                    load_result_c = 1'b1;
                    state_next    = cur_bit ? ST_MU_GO : ST_NEXT;
                end
            end

            ST_MU_GO: begin
                sel_x_c     = SEL_A;
                sel_y_c     = SEL_B;
                mul_start_c = 1'b1;
                state_next  = ST_MU_WAIT;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
                seen_one_next = 1'b1;
`endif
            end

            ST_MU_WAIT: begin
                sel_x_c = SEL_A;
                sel_y_c = SEL_B;
                if (bus.mul_done) begin
                    load_result_c = 1'b1;
                    state_next    = ST_NEXT;
                end
            end

            ST_NEXT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_dec;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
                    // Leading zeros only walk the counter; the first 1 bit multiplies 1*B directly.
                    if (seen_one_reg)
                        state_next = ST_SQ_GO;
                    else if (exp_reg[cnt_dec])
                        state_next = ST_MU_GO;
                    else
                        state_next = ST_NEXT;
`else
                    state_next = ST_SQ_GO;
`endif
                end
            end

            ST_DONE: begin
                done_c     = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.sel_x       = sel_x_c;
    assign bus.sel_y       = sel_y_c;
    assign bus.mul_start   = mul_start_c;
    assign bus.load_result = load_result_c;
    assign bus.done        = done_c;
    assign bus.busy        = (state_reg != ST_IDLE);

endmodule
